// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the 16-bit processor datapath.
//   DATA_W   : architectural register width
//   NREG     : number of general-purpose registers
//   REG_AW   : register index width
//   regidx_t : register index type
//   word_t   : architectural data word type
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int REG_AW = 4;

  typedef logic [REG_AW-1:0] regidx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/decoder4to16.sv
// ---------------------------------------------------------------------------
// decoder4to16
// 4-to-16 line decoder with enable. Exactly one output bit is high when
// en is high; all outputs are low when en is low.
// Ports:
//   A  : in  [3:0]  select
//   en : in         enable
//   D  : out [15:0] one-hot output, D[A] = en
// ---------------------------------------------------------------------------
module decoder4to16 (
  input  logic [3:0]  A,
  input  logic        en,
  output logic [15:0] D
);

  always_comb begin
    D = '0;
    if (en) begin
      D[A] = 1'b1;
    end
  end

endmodule : decoder4to16

// File: rtl/reg_file16.sv
// ---------------------------------------------------------------------------
// reg_file16
// 16 x DATA_W register file: one write port, two combinational read ports,
// and a per-register pending-write scoreboard used by issue logic for RAW
// hazard detection.
//
// Parameters:
//   DATA_W  : register width
//   BYPASS  : 1 = same-cycle write data forwarded to matching read ports
//   ZERO_R0 : 1 = r0 hardwired to zero, never written, never pending
//
// Ports:
//   clk      : in          system clock, rising edge
//   rst_n    : in          asynchronous active-low reset
//   we       : in          write enable
//   waddr    : in  [3:0]   write register index
//   wdata    : in  [W-1:0] write data
//   raddr_a  : in  [3:0]   read port A index
//   rdata_a  : out [W-1:0] read port A data (combinational)
//   raddr_b  : in  [3:0]   read port B index
//   rdata_b  : out [W-1:0] read port B data (combinational)
//   rsv_en   : in          reserve strobe (mark destination pending)
//   rsv_addr : in  [3:0]   register index to reserve
//   pend_a   : out         registered pending bit of raddr_a
//   pend_b   : out         registered pending bit of raddr_b
//   pend_vec : out [15:0]  all pending bits, bit i = register i
// ---------------------------------------------------------------------------
module reg_file16 #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [3:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              rsv_en,
  input  logic [3:0]        rsv_addr,
  output logic              pend_a,
  output logic              pend_b,
  output logic [15:0]       pend_vec
);

  import cpu_pkg::*;

  // r0 is masked out of both strobes when hardwired to zero, so its storage
  // and pending bit simply never leave their reset value.
  localparam logic [NREG-1:0] R0_MASK = (ZERO_R0 != 0) ? {{(NREG-1){1'b0}}, 1'b1}
                                                       : {NREG{1'b0}};

  logic [NREG-1:0]   wr_stb;
  logic [NREG-1:0]   rsv_stb;
  logic [NREG-1:0]   wr_en;
  logic [NREG-1:0]   rsv_set;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   pend_q;
  logic [NREG-1:0]   pend_d;

  decoder4to16 u_wr_dec (
    .A  (waddr),
    .en (we),
    .D  (wr_stb)
  );

  decoder4to16 u_rsv_dec (
    .A  (rsv_addr),
    .en (rsv_en),
    .D  (rsv_stb)
  );

  assign wr_en   = wr_stb  & ~R0_MASK;
  assign rsv_set = rsv_stb & ~R0_MASK;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = wr_en[i] ? wdata : regs_q[i];
    end
  end

  // Reserve has priority over the clearing write so that a same-cycle
  // reserve + write leaves the register owned by the new producer.
  assign pend_d = rsv_set | (pend_q & ~wr_stb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q <= pend_d;
    end
  end

  // Read muxes. rst_n gates the bypass path so outputs read zero while reset
  // is held even if a write is being presented.
  always_comb begin
    rdata_a = regs_q[raddr_a];
    if ((BYPASS != 0) && we && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
    if (((ZERO_R0 != 0) && (raddr_a == 4'd0)) || !rst_n) begin
      rdata_a = '0;
    end
  end

  always_comb begin
    rdata_b = regs_q[raddr_b];
    if ((BYPASS != 0) && we && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
    if (((ZERO_R0 != 0) && (raddr_b == 4'd0)) || !rst_n) begin
      rdata_b = '0;
    end
  end

  // Pending outputs come from the registered bits only; a same-cycle
  // reserve is deliberately not forwarded.
  assign pend_a   = pend_q[raddr_a];
  assign pend_b   = pend_q[raddr_b];
  assign pend_vec = pend_q;

endmodule : reg_file16

// File: tb/tb_reg_file16.sv
module tb_reg_file16;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [3:0]  raddr_a;
  logic [3:0]  raddr_b;
  logic        rsv_en;
  logic [3:0]  rsv_addr;

  // dut0: BYPASS=1, ZERO_R0=1 ; dut1: BYPASS=0, ZERO_R0=0
  logic [15:0] rdata_a0, rdata_b0, pend_vec0;
  logic        pend_a0, pend_b0;
  logic [15:0] rdata_a1, rdata_b1, pend_vec1;
  logic        pend_a1, pend_b1;

  reg_file16 #(.DATA_W(16), .BYPASS(1), .ZERO_R0(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a0), .raddr_b(raddr_b), .rdata_b(rdata_b0),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_a(pend_a0), .pend_b(pend_b0), .pend_vec(pend_vec0)
  );

  reg_file16 #(.DATA_W(16), .BYPASS(0), .ZERO_R0(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a1), .raddr_b(raddr_b), .rdata_b(rdata_b1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_a(pend_a1), .pend_b(pend_b1), .pend_vec(pend_vec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a0, b0, pv0;
    logic        pa0, pb0;
    logic [15:0] a1, b1, pv1;
    logic        pa1, pb1;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit stim_done = 1'b0;

  // Reference model: plain arrays of register contents and pending flags.
  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];
  bit          pnd0 [16];
  bit          pnd1 [16];

  function automatic logic [15:0] model_read(input logic [15:0] mem[16], input int idx,
                                             input bit bypass, input bit zr0);
    if (!rst_n) return 16'h0;
    if (zr0 && idx == 0) return 16'h0;
    if (bypass && we && int'(waddr) == idx) return wdata;
    return mem[idx];
  endfunction

  function automatic logic [15:0] pvec(input bit p[16]);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = p[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 16'h0; mem1[i] = 16'h0; pnd0[i] = 1'b0; pnd1[i] = 1'b0;
    end
  endtask

  // Apply the inputs that were present at the rising edge just taken.
  task automatic model_edge();
    if (!rst_n) return;
    for (int i = 0; i < 16; i++) begin
      if (rsv_en && int'(rsv_addr) == i) begin
        pnd0[i] = (i != 0);
        pnd1[i] = 1'b1;
      end else if (we && int'(waddr) == i) begin
        pnd0[i] = 1'b0;
        pnd1[i] = 1'b0;
      end
    end
    if (we) begin
      if (waddr != 4'd0) mem0[waddr] = wdata;
      mem1[waddr] = wdata;
    end
  endtask

  task automatic issue(input bit r, input bit w, input int wa, input logic [15:0] wd,
                       input int ra, input int rb, input bit rs, input int rsa);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    rst_n = r; we = w; waddr = 4'(wa); wdata = wd;
    raddr_a = 4'(ra); raddr_b = 4'(rb); rsv_en = rs; rsv_addr = 4'(rsa);
    if (!r) model_clear();
    e.a0  = model_read(mem0, ra, 1'b1, 1'b1);
    e.b0  = model_read(mem0, rb, 1'b1, 1'b1);
    e.pa0 = pnd0[ra];
    e.pb0 = pnd0[rb];
    e.pv0 = pvec(pnd0);
    e.a1  = model_read(mem1, ra, 1'b0, 1'b0);
    e.b1  = model_read(mem1, rb, 1'b0, 1'b0);
    e.pa1 = pnd1[ra];
    e.pb1 = pnd1[rb];
    e.pv1 = pvec(pnd1);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so each issued cycle is sampled at
  // the following falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rdata_a bp1z1", rdata_a0, e.a0);
        chk("rdata_b bp1z1", rdata_b0, e.b0);
        chk("pend_a bp1z1", {15'h0, pend_a0}, {15'h0, e.pa0});
        chk("pend_b bp1z1", {15'h0, pend_b0}, {15'h0, e.pb0});
        chk("pend_vec bp1z1", pend_vec0, e.pv0);
        chk("rdata_a bp0z0", rdata_a1, e.a1);
        chk("rdata_b bp0z0", rdata_b1, e.b1);
        chk("pend_a bp0z0", {15'h0, pend_a1}, {15'h0, e.pa1});
        chk("pend_b bp0z0", {15'h0, pend_b1}, {15'h0, e.pb1});
        chk("pend_vec bp0z0", pend_vec1, e.pv1);
      end
    end
  end

  initial begin
    int wa, ra, rb;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; rsv_en = 1'b0; rsv_addr = '0;
    model_clear();

    // Reset held, then read sweep.
    issue(0, 0, 0, 16'h0, 0, 0, 0, 0);
    issue(0, 0, 0, 16'h0, 1, 2, 0, 0);
    for (int i = 0; i < 16; i++) issue(1, 0, 0, 16'h0, i, 15 - i, 0, 0);

    // Write r0 with all-ones, then r1..r15 with a pattern, then read back.
    issue(1, 1, 0, 16'hFFFF, 0, 1, 0, 0);
    for (int i = 1; i < 16; i++) issue(1, 1, i, 16'hA500 | 16'(i), 0, i, 0, 0);
    for (int i = 0; i < 16; i++) issue(1, 0, 0, 16'h0, i, 15 - i, 0, 0);

    // Bypass on port A only, then confirm stored value.
    issue(1, 1, 5, 16'h1234, 5, 6, 0, 0);
    issue(1, 0, 0, 16'h0, 5, 6, 0, 0);
    // Both ports bypass at once.
    issue(1, 1, 8, 16'h5A5A, 8, 8, 0, 0);

    // Scoreboard set then clear via write.
    issue(1, 0, 0, 16'h0, 3, 3, 1, 3);
    issue(1, 1, 3, 16'hBEEF, 3, 0, 0, 0);
    issue(1, 0, 0, 16'h0, 3, 3, 0, 0);

    // Reserve of r0 and reserve of an already pending register.
    issue(1, 0, 0, 16'h0, 0, 4, 1, 0);
    issue(1, 0, 0, 16'h0, 0, 4, 1, 4);
    issue(1, 0, 0, 16'h0, 4, 0, 1, 4);

    // Simultaneous reserve and write on r7; reserve r2 while writing r9.
    issue(1, 1, 7, 16'h00C3, 7, 9, 1, 7);
    issue(1, 1, 9, 16'h0999, 7, 9, 1, 2);
    issue(1, 0, 0, 16'h0, 7, 9, 0, 0);
    issue(1, 0, 0, 16'h0, 2, 7, 0, 0);

    // Reset asserted mid-operation with a write presented, then released.
    issue(0, 1, 6, 16'h6666, 6, 7, 1, 6);
    issue(1, 0, 0, 16'h0, 6, 7, 0, 0);

    // Randomised sweep with occasional reset pulses.
    for (int n = 0; n < 10000; n++) begin
      wa = $urandom_range(15);
      ra = ($urandom_range(3) == 0) ? wa : $urandom_range(15);
      rb = ($urandom_range(3) == 0) ? wa : $urandom_range(15);
      issue(($urandom_range(299) != 0), $urandom_range(1) == 1, wa, 16'($urandom),
            ra, rb, $urandom_range(2) == 0, $urandom_range(15));
    end
    issue(1, 0, 0, 16'h0, 0, 0, 0, 0);

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_file16
